// File: rtl/sdr_init_refresh_checker.sv
// -----------------------------------------------------------------------------
// sdr_init_refresh_checker
//
// Protocol checker for the SDRAM command bus. It sits beside the controller on
// the pad side and follows the JEDEC-style initialisation sequence:
//   power-up idle -> PRE -> tRP -> N_REF x (REF + tRFC) -> MRS -> tMRD -> RUN
// Once in RUN it keeps checking tRFC after every REF. A watchdog also flags
// refresh intervals that reach T_REF_MAX cycles.
//
// Ports
//   sdram_clk     : clock
//   sdram_resetn  : synchronous active-low reset
//   chk_en        : 1 = checking active, 0 = FSM and all counters frozen
//   clr_err       : clears err_o / err_code_o / err_cnt_o on the next edge
//   sdr_cs_n, sdr_ras_n, sdr_cas_n, sdr_we_n : observed command bus
//   init_done_o   : high while the FSM is in RUN (legal init completed)
//   err_o         : sticky error flag
//   err_code_o    : code of the first error since the last clear
//                   1 power-up too short, 2 illegal command order,
//                   3 tRP, 4 tRFC, 5 tMRD, 6 refresh interval
//   err_cnt_o     : saturating error count
//   ref_cnt_o     : wrapping count of REF commands seen in RUN
// -----------------------------------------------------------------------------
module sdr_init_refresh_checker #(
    parameter int N_PWRUP_CYC = 100,
    parameter int N_REF       = 2,
    parameter int T_RP        = 3,
    parameter int T_RFC       = 7,
    parameter int T_MRD       = 2,
    parameter int T_REF_MAX   = 1560,
    parameter int ERR_CNT_W   = 8
) (
    input  logic                 sdram_clk,
    input  logic                 sdram_resetn,
    input  logic                 chk_en,
    input  logic                 clr_err,
    input  logic                 sdr_cs_n,
    input  logic                 sdr_ras_n,
    input  logic                 sdr_cas_n,
    input  logic                 sdr_we_n,
    output logic                 init_done_o,
    output logic                 err_o,
    output logic [3:0]           err_code_o,
    output logic [ERR_CNT_W-1:0] err_cnt_o,
    output logic [15:0]          ref_cnt_o
);

    // One shared gap counter covers the power-up idle and every timing gap,
    // so it is sized for the largest of them and saturates there.
    localparam int GAP_MAX_A = (N_PWRUP_CYC > T_RP)  ? N_PWRUP_CYC : T_RP;
    localparam int GAP_MAX_B = (T_RFC > T_MRD)       ? T_RFC       : T_MRD;
    localparam int GAP_MAX   = (GAP_MAX_A > GAP_MAX_B) ? GAP_MAX_A : GAP_MAX_B;
    localparam int GAP_W     = $clog2(GAP_MAX + 2);
    localparam int WD_W      = $clog2(T_REF_MAX + 1);
    localparam int IREF_W    = $clog2(N_REF + 2);

    localparam logic [GAP_W-1:0]     GAP_SAT   = GAP_W'(GAP_MAX);
    localparam logic [GAP_W-1:0]     GAP_PWRUP = GAP_W'(N_PWRUP_CYC);
    localparam logic [GAP_W-1:0]     GAP_RP    = GAP_W'(T_RP);
    localparam logic [GAP_W-1:0]     GAP_RFC   = GAP_W'(T_RFC);
    localparam logic [GAP_W-1:0]     GAP_MRD   = GAP_W'(T_MRD);
    localparam logic [WD_W-1:0]      WD_LAST   = WD_W'(T_REF_MAX - 1);
    localparam logic [IREF_W-1:0]    IREF_N    = IREF_W'(N_REF);
    localparam logic [ERR_CNT_W-1:0] ERR_ONE   = ERR_CNT_W'(1);
    localparam logic [ERR_CNT_W-1:0] ERR_SAT   = {ERR_CNT_W{1'b1}};

    // {ras_n, cas_n, we_n} encodings with cs_n low
    localparam logic [2:0] C_NOP = 3'b111;
    localparam logic [2:0] C_PRE = 3'b010;
    localparam logic [2:0] C_REF = 3'b001;
    localparam logic [2:0] C_MRS = 3'b000;

    localparam logic [3:0] E_PWRUP = 4'd1;
    localparam logic [3:0] E_ORDER = 4'd2;
    localparam logic [3:0] E_TRP   = 4'd3;
    localparam logic [3:0] E_TRFC  = 4'd4;
    localparam logic [3:0] E_TMRD  = 4'd5;
    localparam logic [3:0] E_WDOG  = 4'd6;

    typedef enum logic [2:0] {
        S_PWRUP,
        S_TRP,
        S_REFS,
        S_TMRD,
        S_RUN,
        S_FAIL
    } state_t;

    state_t                 state_q, state_d;
    logic [GAP_W-1:0]       gap_q, gap_d, gap_nx;
    logic [WD_W-1:0]        wd_q, wd_d;
    logic [IREF_W-1:0]      iref_q, iref_d;
    logic                   rfc_open_q, rfc_open_d;
    logic [15:0]            ref_cnt_q, ref_cnt_d;
    logic                   err_q;
    logic [3:0]             err_code_q;
    logic [ERR_CNT_W-1:0]   err_cnt_q;

    logic [2:0]             cmd;
    logic                   is_idle, is_pre, is_ref, is_mrs;
    logic                   err_fire;
    logic [3:0]             err_code_new;
    logic                   rfc_err, wdog_hit;

    function automatic logic [GAP_W-1:0] gap_inc(input logic [GAP_W-1:0] v);
        return (v >= GAP_SAT) ? v : v + GAP_W'(1);
    endfunction

    function automatic logic [ERR_CNT_W-1:0] err_sat_inc(input logic [ERR_CNT_W-1:0] v);
        return (v == ERR_SAT) ? v : v + ERR_ONE;
    endfunction

    // Command decode
    assign cmd     = {sdr_ras_n, sdr_cas_n, sdr_we_n};
    assign is_idle = sdr_cs_n | (cmd == C_NOP);
    assign is_pre  = ~sdr_cs_n & (cmd == C_PRE);
    assign is_ref  = ~sdr_cs_n & (cmd == C_REF);
    assign is_mrs  = ~sdr_cs_n & (cmd == C_MRS);
    assign gap_nx  = gap_inc(gap_q);

    // Next-state, counter and error-detect logic
    always_comb begin
        state_d      = state_q;
        gap_d        = gap_q;
        wd_d         = wd_q;
        iref_d       = iref_q;
        rfc_open_d   = rfc_open_q;
        ref_cnt_d    = ref_cnt_q;
        err_fire     = 1'b0;
        err_code_new = 4'd0;
        rfc_err      = 1'b0;
        wdog_hit     = 1'b0;

        if (chk_en) begin
            case (state_q)
                S_PWRUP: begin
                    if (is_idle) begin
                        gap_d = gap_nx;
                    end else if (gap_q < GAP_PWRUP) begin
                        err_fire = 1'b1; err_code_new = E_PWRUP; state_d = S_FAIL;
                    end else if (is_pre) begin
                        state_d = S_TRP; gap_d = '0;
                    end else begin
                        err_fire = 1'b1; err_code_new = E_ORDER; state_d = S_FAIL;
                    end
                end
                S_TRP: begin
                    if (is_idle) begin
                        gap_d = gap_nx;
                    end else if (gap_q < GAP_RP) begin
                        err_fire = 1'b1; err_code_new = E_TRP; state_d = S_FAIL;
                    end else if (is_ref) begin
                        state_d = S_REFS; gap_d = '0; iref_d = IREF_W'(1);
                    end else begin
                        err_fire = 1'b1; err_code_new = E_ORDER; state_d = S_FAIL;
                    end
                end
                S_REFS: begin
                    if (is_idle) begin
                        gap_d = gap_nx;
                    end else if (gap_q < GAP_RFC) begin
                        err_fire = 1'b1; err_code_new = E_TRFC; state_d = S_FAIL;
                    end else if (is_ref && (iref_q < IREF_N)) begin
                        iref_d = iref_q + IREF_W'(1); gap_d = '0;
                    end else if (is_mrs && (iref_q == IREF_N)) begin
                        state_d = S_TMRD; gap_d = '0;
                    end else begin
                        // early MRS, surplus REF or any other command
                        err_fire = 1'b1; err_code_new = E_ORDER; state_d = S_FAIL;
                    end
                end
                S_TMRD: begin
                    if (!is_idle) begin
                        err_fire = 1'b1; err_code_new = E_TMRD; state_d = S_FAIL;
                    end else if (gap_nx >= GAP_MRD) begin
                        state_d    = S_RUN;
                        gap_d      = '0;
                        wd_d       = '0;
                        rfc_open_d = 1'b0;
                    end else begin
                        gap_d = gap_nx;
                    end
                end
                S_RUN: begin
                    // refresh-interval watchdog
                    if (is_ref) begin
                        wd_d = '0;
                    end else if (wd_q == WD_LAST) begin
                        wd_d     = '0;
                        wdog_hit = 1'b1;
                    end else begin
                        wd_d = wd_q + WD_W'(1);
                    end

                    // tRFC gap after a REF; a violating command ends the gap
                    if (rfc_open_q) begin
                        if (is_idle) begin
                            gap_d = gap_nx;
                            if (gap_nx >= GAP_RFC) rfc_open_d = 1'b0;
                        end else begin
                            rfc_err    = 1'b1;
                            rfc_open_d = 1'b0;
                        end
                    end

                    // every REF counts (even a violating one) and reopens the gap
                    if (is_ref) begin
                        ref_cnt_d  = ref_cnt_q + 16'd1;
                        gap_d      = '0;
                        rfc_open_d = (GAP_RFC != '0);
                    end

                    if (rfc_err) begin
                        err_fire = 1'b1; err_code_new = E_TRFC;
                    end else if (wdog_hit) begin
                        err_fire = 1'b1; err_code_new = E_WDOG;
                    end
                end
                S_FAIL: begin
                    state_d = S_FAIL;
                end
                default: begin
                    state_d = S_PWRUP;
                end
            endcase
        end
    end

    // State, counters and error record
    always_ff @(posedge sdram_clk) begin
        if (!sdram_resetn) begin
            state_q    <= S_PWRUP;
            gap_q      <= '0;
            wd_q       <= '0;
            iref_q     <= '0;
            rfc_open_q <= 1'b0;
            ref_cnt_q  <= '0;
            err_q      <= 1'b0;
            err_code_q <= 4'd0;
            err_cnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            gap_q      <= gap_d;
            wd_q       <= wd_d;
            iref_q     <= iref_d;
            rfc_open_q <= rfc_open_d;
            ref_cnt_q  <= ref_cnt_d;

            // A new error beats a coincident clear: it restarts the record.
            if (err_fire) begin
                err_q <= 1'b1;
                if (!err_q || clr_err) err_code_q <= err_code_new;
                err_cnt_q <= clr_err ? ERR_ONE : err_sat_inc(err_cnt_q);
            end else if (clr_err) begin
                err_q      <= 1'b0;
                err_code_q <= 4'd0;
                err_cnt_q  <= '0;
            end
        end
    end

    assign init_done_o = (state_q == S_RUN);
    assign err_o       = err_q;
    assign err_code_o  = err_code_q;
    assign err_cnt_o   = err_cnt_q;
    assign ref_cnt_o   = ref_cnt_q;

endmodule

// File: tb/tb_sdr_init_refresh_checker.sv
// -----------------------------------------------------------------------------
// tb_sdr_init_refresh_checker
//
// Directed bench for sdr_init_refresh_checker. A default-parameter instance is
// exercised by a vector table (legal init followed by RUN-mode checks) and by
// short hand-written sequences for init violations. A second instance with
// N_REF=8 shares the same bus to check the REF-count parameter.
// -----------------------------------------------------------------------------
module tb_sdr_init_refresh_checker;

    logic        clk = 1'b0;
    logic        resetn;
    logic        chk_en;
    logic        clr_err;
    logic        cs_n, ras_n, cas_n, we_n;

    logic        done, err;
    logic [3:0]  code;
    logic [7:0]  cnt;
    logic [15:0] refc;

    logic        done8, err8;
    logic [3:0]  code8;
    logic [7:0]  cnt8;
    logic [15:0] refc8;

    int checks = 0;
    int errors = 0;

    // {cs_n, ras_n, cas_n, we_n}
    localparam logic [3:0] NOP = 4'b0111;
    localparam logic [3:0] DES = 4'b1111;
    localparam logic [3:0] PRE = 4'b0010;
    localparam logic [3:0] REF = 4'b0001;
    localparam logic [3:0] MRS = 4'b0000;
    localparam logic [3:0] ACT = 4'b0011;
    localparam logic [3:0] RD  = 4'b0101;
    localparam logic [3:0] WR  = 4'b0100;

    always #5 clk = ~clk;

    sdr_init_refresh_checker u_dut (
        .sdram_clk    (clk),
        .sdram_resetn (resetn),
        .chk_en       (chk_en),
        .clr_err      (clr_err),
        .sdr_cs_n     (cs_n),
        .sdr_ras_n    (ras_n),
        .sdr_cas_n    (cas_n),
        .sdr_we_n     (we_n),
        .init_done_o  (done),
        .err_o        (err),
        .err_code_o   (code),
        .err_cnt_o    (cnt),
        .ref_cnt_o    (refc)
    );

    sdr_init_refresh_checker #(.N_REF(8)) u_dut8 (
        .sdram_clk    (clk),
        .sdram_resetn (resetn),
        .chk_en       (chk_en),
        .clr_err      (clr_err),
        .sdr_cs_n     (cs_n),
        .sdr_ras_n    (ras_n),
        .sdr_cas_n    (cas_n),
        .sdr_we_n     (we_n),
        .init_done_o  (done8),
        .err_o        (err8),
        .err_code_o   (code8),
        .err_cnt_o    (cnt8),
        .ref_cnt_o    (refc8)
    );

    typedef struct {
        string       name;
        logic [3:0]  cmd;
        int          n;
        logic        en;
        logic        clr;
        logic        chk;
        logic        e_done;
        logic        e_err;
        logic [3:0]  e_code;
        logic [7:0]  e_cnt;
        logic [15:0] e_ref;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input string nm, input logic [3:0] c, input int n,
                                input logic en, input logic clr, input logic chk,
                                input logic d, input logic e, input logic [3:0] cd,
                                input logic [7:0] ct, input logic [15:0] r);
        vec_t v;
        v.name = nm; v.cmd = c; v.n = n; v.en = en; v.clr = clr; v.chk = chk;
        v.e_done = d; v.e_err = e; v.e_code = cd; v.e_cnt = ct; v.e_ref = r;
        return v;
    endfunction

    // Drive one command for n cycles; outputs are sampled 1 time unit after the edge.
    task automatic drive(input logic [3:0] c, input int n, input logic en, input logic clr);
        for (int i = 0; i < n; i++) begin
            {cs_n, ras_n, cas_n, we_n} = c;
            chk_en  = en;
            clr_err = clr;
            @(posedge clk);
            #1;
        end
        {cs_n, ras_n, cas_n, we_n} = NOP;
        clr_err = 1'b0;
        chk_en  = 1'b1;
    endtask

    task automatic run(input logic [3:0] c, input int n);
        drive(c, n, 1'b1, 1'b0);
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        run(NOP, 2);
        resetn = 1'b1;
    endtask

    task automatic check(input string nm, input logic e_done, input logic e_err,
                         input logic [3:0] e_code, input logic [7:0] e_cnt,
                         input logic [15:0] e_ref);
        checks++;
        if ({done, err, code, cnt, refc} !== {e_done, e_err, e_code, e_cnt, e_ref}) begin
            errors++;
            $display("FAIL %s: got done=%0b err=%0b code=%0d cnt=%0d ref=%0d, want done=%0b err=%0b code=%0d cnt=%0d ref=%0d",
                     nm, done, err, code, cnt, refc, e_done, e_err, e_code, e_cnt, e_ref);
        end
    endtask

    task automatic check8(input string nm, input logic e_done, input logic e_err,
                          input logic [3:0] e_code, input logic [7:0] e_cnt);
        checks++;
        if ({done8, err8, code8, cnt8} !== {e_done, e_err, e_code, e_cnt}) begin
            errors++;
            $display("FAIL %s: got done=%0b err=%0b code=%0d cnt=%0d, want done=%0b err=%0b code=%0d cnt=%0d",
                     nm, done8, err8, code8, cnt8, e_done, e_err, e_code, e_cnt);
        end
    endtask

    task automatic legal_init();
        run(NOP, 100); run(PRE, 1); run(NOP, 3);
        run(REF, 1);   run(NOP, 7);
        run(REF, 1);   run(NOP, 7);
        run(MRS, 1);   run(NOP, 2);
    endtask

    initial begin
        #5ms;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        resetn  = 1'b0;
        chk_en  = 1'b1;
        clr_err = 1'b0;
        {cs_n, ras_n, cas_n, we_n} = NOP;

        //            name            cmd  n     en clr chk done err code cnt ref
        tbl.push_back(mk("pwrup_nop",   NOP, 60,   1, 0, 1, 0, 0, 0, 0, 0));
        tbl.push_back(mk("pwrup_des",   DES, 40,   1, 0, 1, 0, 0, 0, 0, 0));
        tbl.push_back(mk("pre",         PRE, 1,    1, 0, 1, 0, 0, 0, 0, 0));
        tbl.push_back(mk("trp_gap",     NOP, 3,    1, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk("ref1",        REF, 1,    1, 0, 1, 0, 0, 0, 0, 0));
        tbl.push_back(mk("rfc1_gap",    NOP, 7,    1, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk("ref2",        REF, 1,    1, 0, 1, 0, 0, 0, 0, 0));
        tbl.push_back(mk("rfc2_gap",    DES, 7,    1, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk("mrs",         MRS, 1,    1, 0, 1, 0, 0, 0, 0, 0));
        tbl.push_back(mk("mrd_1",       NOP, 1,    1, 0, 1, 0, 0, 0, 0, 0));
        tbl.push_back(mk("init_done",   NOP, 1,    1, 0, 1, 1, 0, 0, 0, 0));
        tbl.push_back(mk("wd_1559",     NOP, 1559, 1, 0, 1, 1, 0, 0, 0, 0));
        tbl.push_back(mk("wd_1560",     NOP, 1,    1, 0, 1, 1, 1, 6, 1, 0));
        tbl.push_back(mk("wd_1569",     NOP, 9,    1, 0, 1, 1, 1, 6, 1, 0));
        tbl.push_back(mk("ref_1570",    REF, 1,    1, 0, 1, 1, 1, 6, 1, 1));
        tbl.push_back(mk("run_1600",    NOP, 30,   1, 0, 1, 1, 1, 6, 1, 1));
        tbl.push_back(mk("run_ref2",    REF, 1,    1, 0, 1, 1, 1, 6, 1, 2));
        tbl.push_back(mk("rfc_part",    NOP, 3,    1, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk("clr_vs_trfc", ACT, 1,    1, 1, 1, 1, 1, 4, 1, 2));
        tbl.push_back(mk("en0_nop",     NOP, 1000, 0, 0, 1, 1, 1, 4, 1, 2));
        tbl.push_back(mk("en0_ref",     REF, 1,    0, 0, 1, 1, 1, 4, 1, 2));
        tbl.push_back(mk("en0_act",     ACT, 1,    0, 0, 1, 1, 1, 4, 1, 2));
        tbl.push_back(mk("en0_2000",    NOP, 998,  0, 0, 1, 1, 1, 4, 1, 2));
        tbl.push_back(mk("en0_clr",     NOP, 1,    0, 1, 1, 1, 0, 0, 0, 2));
        tbl.push_back(mk("wd_resume",   NOP, 1555, 1, 0, 1, 1, 0, 0, 0, 2));
        tbl.push_back(mk("wd_resume_hit", NOP, 1,  1, 0, 1, 1, 1, 6, 1, 2));
        tbl.push_back(mk("clr",         NOP, 1,    1, 1, 1, 1, 0, 0, 0, 2));
        tbl.push_back(mk("ref3",        REF, 1,    1, 0, 1, 1, 0, 0, 0, 3));
        tbl.push_back(mk("rfc_full",    NOP, 7,    1, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk("act_T8_ok",   ACT, 1,    1, 0, 1, 1, 0, 0, 0, 3));
        tbl.push_back(mk("ref4",        REF, 1,    1, 0, 1, 1, 0, 0, 0, 4));
        tbl.push_back(mk("rfc_short",   NOP, 6,    1, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk("rd_T7_bad",   RD,  1,    1, 0, 1, 1, 1, 4, 1, 4));

        do_reset();
        check("reset_state", 0, 0, 0, 0, 0);

        foreach (tbl[i]) begin
            drive(tbl[i].cmd, tbl[i].n, tbl[i].en, tbl[i].clr);
            if (tbl[i].chk)
                check(tbl[i].name, tbl[i].e_done, tbl[i].e_err, tbl[i].e_code,
                      tbl[i].e_cnt, tbl[i].e_ref);
        end

        // Error counter saturation: every WR lands inside the tRFC gap of the REF before it.
        for (int k = 1; k <= 300; k++) begin
            run(REF, 1);
            run(WR, 1);
            if (k == 100) check("cnt_101", 1, 1, 4, 8'd101, 16'd104);
        end
        check("cnt_saturated", 1, 1, 4, 8'd255, 16'd304);

        // Power-up violation; FAIL is terminal
        do_reset();
        check("reset_clears", 0, 0, 0, 0, 0);
        run(NOP, 50); run(ACT, 1);
        check("pwrup_short", 0, 1, 1, 1, 0);
        run(NOP, 200); run(PRE, 1); run(NOP, 3); run(REF, 1);
        check("fail_terminal", 0, 1, 1, 1, 0);

        // Power-up boundary: PRE on idle cycle 100 is one too early
        do_reset();
        run(NOP, 99); run(PRE, 1);
        check("pwrup_99", 0, 1, 1, 1, 0);

        // Wrong first command after a full power-up
        do_reset();
        run(NOP, 100); run(REF, 1);
        check("pwrup_not_pre", 0, 1, 2, 1, 0);

        // tRP too short
        do_reset();
        run(NOP, 100); run(PRE, 1); run(NOP, 2); run(REF, 1);
        check("trp_short", 0, 1, 3, 1, 0);

        // Wrong command after tRP
        do_reset();
        run(NOP, 100); run(PRE, 1); run(NOP, 3); run(MRS, 1);
        check("trp_wrong_cmd", 0, 1, 2, 1, 0);

        // tRFC violation during init, then clear; FAIL stays silent
        do_reset();
        run(NOP, 100); run(PRE, 1); run(NOP, 3); run(REF, 1); run(NOP, 4); run(REF, 1);
        check("init_trfc", 0, 1, 4, 1, 0);
        drive(NOP, 1, 1'b1, 1'b1);
        check("init_trfc_clr", 0, 0, 0, 0, 0);
        run(ACT, 1); run(NOP, 10); run(MRS, 1);
        check("fail_no_count", 0, 0, 0, 0, 0);

        // MRS after only one REF
        do_reset();
        run(NOP, 100); run(PRE, 1); run(NOP, 3); run(REF, 1); run(NOP, 7); run(MRS, 1);
        check("mrs_1ref", 0, 1, 2, 1, 0);

        // Two REFs then MRS: legal for N_REF=2, order error for N_REF=8
        do_reset();
        legal_init();
        check("nref2_done", 1, 0, 0, 0, 0);
        check8("nref8_mrs_early", 0, 1, 2, 1);

        // Eight REFs then MRS: surplus REF for N_REF=2, legal for N_REF=8
        do_reset();
        run(NOP, 100); run(PRE, 1); run(NOP, 3); run(REF, 1);
        for (int r = 0; r < 7; r++) begin
            run(NOP, 7); run(REF, 1);
        end
        run(NOP, 7); run(MRS, 1); run(NOP, 2);
        check("nref2_extra_ref", 0, 1, 2, 1, 0);
        check8("nref8_done", 1, 0, 0, 0);

        // tMRD too short
        do_reset();
        run(NOP, 100); run(PRE, 1); run(NOP, 3); run(REF, 1); run(NOP, 7);
        run(REF, 1); run(NOP, 7); run(MRS, 1); run(NOP, 1); run(ACT, 1);
        check("tmrd_short", 0, 1, 5, 1, 0);

        // Reset in the middle of REFS restarts from power-up
        do_reset();
        run(NOP, 100); run(PRE, 1); run(NOP, 3); run(REF, 1); run(NOP, 3);
        do_reset();
        check("reset_mid_refs", 0, 0, 0, 0, 0);
        legal_init();
        check("reinit_done", 1, 0, 0, 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sdr_init_refresh_checker.md
Name: sdr_init_refresh_checker

Overview:
- Synthesizable protocol checker that watches the SDRAM command bus during and after initialisation.
- It is the parametrised successor of the whitebox init/reset assertions:
  - power-up idle length, precharge, auto-refresh count, MRS and timing gaps are all configurable;
  - a runtime refresh-interval watchdog is added.
- Sits beside sdrc_core on the SDRAM pad side; its outputs feed the testbench scoreboard and an optional debug register.

Parameters:
N_PWRUP_CYC, 100, min idle cycles after reset before the first non-idle command
N_REF, 2, auto-refresh commands required during init
T_RP, 3, min idle cycles after PRE
T_RFC, 7, min idle cycles after REF
T_MRD, 2, min idle cycles after MRS
T_REF_MAX, 1560, max cycles between REFs in run mode
ERR_CNT_W, 8, error counter width

Ports:
sdram_clk  in  1  clock
sdram_resetn  in  1  synchronous active-low reset
chk_en  in  1  1=checking active; 0=FSM/counters frozen, no errors flagged
clr_err  in  1  clears err_o, err_code_o, err_cnt_o
sdr_cs_n  in  1  SDRAM chip select
sdr_ras_n  in  1  RAS
sdr_cas_n  in  1  CAS
sdr_we_n  in  1  WE
init_done_o  out  1  init sequence completed legally
err_o  out  1  sticky error flag
err_code_o  out  4  code of first error since last clear
err_cnt_o  out  ERR_CNT_W  saturating error count
ref_cnt_o  out  16  wrapping count of REFs seen in RUN

Behaviour:
- Decode (ras,cas,we) with cs_n=0:
  - 111 NOP
  - 010 PRE
  - 001 REF
  - 000 MRS
  - 011 ACT
  - 101 RD
  - 100 WR
  - 110 BST
  - cs_n=1 is DESELECT.
- IDLE means NOP or DESELECT.
- Reset: sampled at posedge sdram_clk when sdram_resetn=0. All outputs 0, FSM=PWRUP, counters 0.
- Reset asserted mid-sequence restarts checking from PWRUP.
- FSM:
  - PWRUP: count IDLE cycles. Non-idle command before count reaches N_PWRUP_CYC -> code 1, go FAIL. First non-idle command after that: PRE -> TRP; otherwise code 2, FAIL.
  - TRP: require T_RP IDLE cycles, then next command must be REF. Early non-idle -> code 3; wrong command after the gap -> code 2. Both go FAIL.
  - REFS: after each REF require T_RFC IDLE cycles. Early non-idle -> code 4, FAIL. After a full gap:
    - REF increments the init REF count.
    - MRS is legal only once the count = N_REF; go TMRD.
    - MRS with count < N_REF, a REF beyond N_REF, or any other command -> code 2, FAIL.
  - TMRD: require T_MRD IDLE cycles. Early non-idle -> code 5, FAIL. Once the gap completes -> RUN, init_done_o=1 the same cycle the FSM enters RUN.
  - RUN:
    - Watchdog counts cycles since the last REF, cleared on entry to RUN and on every REF.
    - Counter reaching T_REF_MAX -> code 6, counter clears.
    - REF increments ref_cnt_o (wraps at 2^16) and opens a T_RFC gap; non-idle inside the gap -> code 4.
    - RUN errors do not leave RUN.
  - FAIL: terminal until reset. init_done_o=0. No further errors are counted.
- Error recording (registered, visible the cycle after the offending command):
  - Any error sets err_o=1.
  - err_code_o loads only when err_o was 0 (first-error capture).
  - err_cnt_o increments and saturates at all-ones.
- clr_err=1 clears all three next cycle.
- Simultaneous clr_err and new error: the new error wins; result is err_o=1, err_code_o=new code, err_cnt_o=1.
- chk_en=0 holds FSM state and all counters (gap, watchdog, ref_cnt). Command-bus activity is ignored. clr_err still works.
- Gap counts are exact: a command on idle cycle number T (1-based) after PRE/REF/MRS is legal when T > T_xx.

Test Plan:
- Legal init with defaults: reset, 100 NOP, PRE, 3 NOP, REF, 7 NOP, REF, 7 NOP, MRS, 2 NOP -> init_done_o=1 on cycle after 2nd NOP post-MRS; err_o=0.
- Power-up violation: ACT after 50 NOPs -> err_o=1, err_code_o=1, err_cnt_o=1, init_done_o never rises.
- tRFC violation: legal init up to first REF, then REF after 4 NOPs -> err_code_o=4, FSM in FAIL; a later clr_err -> err_o=0, err_cnt_o=0.
- Refresh watchdog: legal init, then 1600 NOP cycles -> err_code_o=6 after 1560 cycles, err_cnt_o=1; a REF at cycle 1570 -> ref_cnt_o=1, no new error.
- Wrong order with N_REF=8 override: MRS after 2 REFs -> err_code_o=2.
- clr_err coincident with a RUN tRFC violation -> err_o=1, err_code_o=4, err_cnt_o=1.
- chk_en=0 for 2000 cycles in RUN -> no code 6.
- Reset mid-REFS -> outputs 0; a subsequent legal init completes.
